prbs31_checker: RTL
===================

Name: prbs31_checker

Overview:
Serial PRBS31 receiver/checker (polynomial x^31 + x^28 + 1) placed directly downstream of the team's PRBS31 generator, or fed from a loopback pin.
- Self-synchronises to the incoming bit stream, declares lock, then free-runs its own reference.
- Counts bit errors against that reference and drops lock on excessive errors.

Parameters:
ERR_W, 16, width of the saturating error counter
LOCK_CNT, 64, consecutive correct valid bits in VERIFY required to declare lock (2..255)
WIN, 64, window length in valid bits for loss-of-lock evaluation (2..255)
LOSS_THRESH, 8, errors within one window that force loss of lock (1..WIN)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous reset, active-high: 1 = reset
din  input  1  received serial bit
din_valid  input  1  din is sampled only in cycles where this is 1
clear_cnt  input  1  synchronous clear of err_count
locked  output  1  1 while in LOCKED state (registered)
err_pulse  output  1  one-cycle pulse per detected error while LOCKED (registered)
err_count  output  ERR_W  saturating count of errors detected while LOCKED (registered)

Behaviour:
- Clocking and reset: one clock (clk). Reset is synchronous and active-high on the port named rst_n (rst_n=1 resets).
- Reset values: sr[30:0]=0, state=SEED, seed_cnt=0, good_run=0, win_cnt=0, win_err=0; locked=0, err_pulse=0, err_count=0.
- Reset mid-operation: takes effect on the next edge regardless of state. clear_cnt and din are ignored during reset.
- Shift register: sr[0] holds the most recent bit; sr[k] holds the bit k positions older.
  - Prediction: pred = sr[27] ^ sr[30].
  - err = din ^ pred.
- Cycles with din_valid=0: no state, register or counter changes; err_pulse=0.

SEED state:
- Each valid bit: sr <= {sr[29:0], din}; seed_cnt++.
- After the 31st valid bit, go to VERIFY.
- err is not evaluated.

VERIFY state:
- Each valid bit: sr <= {sr[29:0], din} (self-synchronising).
- err=1 resets good_run to 0.
- err=0 increments good_run.
- All-zero guard: good_run is forced to 0 while sr==0 (before the shift), so an all-zero input never locks.
- When good_run reaches LOCK_CNT, go to LOCKED; locked=1 on the following edge.
  - Lock latency from reset with a clean stream: 31+LOCK_CNT valid bits.
- Errors here never touch err_count or err_pulse.

LOCKED state:
- Each valid bit: sr <= {sr[29:0], pred} (free-running reference), so a single flipped input bit produces exactly one error.
- err=1 produces:
  - err_pulse=1 in the next cycle;
  - err_count+1, saturating at 2^ERR_W-1;
  - win_err+1.
- win_cnt counts valid bits 0..WIN-1. On wrap, win_err is cleared; an error on the wrap bit counts in the new window as 1.
- If win_err+err reaches LOSS_THRESH:
  - go to SEED and clear seed_cnt, good_run, win_cnt and win_err;
  - locked=0 on the next edge;
  - err_count is retained.
- On entry to LOCKED, win_cnt=0 and win_err=0.

clear_cnt:
- err_count <= 0, except when the same cycle carries a counted error, in which case err_count <= 1.
- Does not affect state, lock or window counters.

Priority (highest first): reset, then state transition, then counters.

Test Plan:
- Reset, then feed a generator-equivalent stream (register seeded 1, out = bit 30, new bit = b27^b30) with din_valid=1 for 10000 cycles -> locked rises exactly after valid bit 95 (+1 edge); err_count=0; err_pulse never asserts.
- While locked, flip one din bit -> err_pulse high for exactly 1 cycle; err_count=1; locked stays 1; subsequent bits produce no further errors.
- While locked, flip 8 bits within 64 valid bits -> locked falls the cycle after the 8th error; err_count=8; relock after a further 95 clean valid bits; err_count remains 8.
- Hold din=0 with din_valid=1 for 1000 cycles after reset -> locked stays 0; err_count=0.
- Clean stream with din_valid toggling 1/0 each cycle -> lock after 95 valid bits (about 190 cycles); assert clear_cnt in the same cycle as an injected locked error -> err_count=1.
- ERR_W=4, inject 20 spaced errors (below the loss threshold) -> err_count saturates at 15. Then assert rst_n=1 mid-lock for one cycle -> locked=0, err_count=0, err_pulse=0 on the next edge.

Source files
------------

// File: rtl/prbs31_checker.sv
// ----------------------------------------------------------------------------
// prbs31_checker : self-synchronising PRBS31 (x^31 + x^28 + 1) bit-error checker
// Revision 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module prbs31_checker #(
  parameter int ERR_W       = 16,
  parameter int LOCK_CNT    = 64,
  parameter int WIN         = 64,
  parameter int LOSS_THRESH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_valid,
  input  logic             clear_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [7:0]       LOCK_LAST = 8'(LOCK_CNT - 1);
  localparam logic [7:0]       WIN_LAST  = 8'(WIN - 1);
  localparam logic [7:0]       THRESH    = 8'(LOSS_THRESH);
  localparam logic [ERR_W-1:0] CNT_ONE   = ERR_W'(1);
  localparam logic [ERR_W-1:0] CNT_MAX   = {ERR_W{1'b1}};

  state_t           state, state_nx;
  logic [30:0]      sr, sr_nx;
  logic [4:0]       seed_cnt, seed_cnt_nx;
  logic [7:0]       good_run, good_run_nx;
  logic [7:0]       win_cnt, win_cnt_nx;
  logic [7:0]       win_err, win_err_nx;
  logic [7:0]       win_sum;
  logic [ERR_W-1:0] count_nx;
  logic             pulse_nx;
  logic             pred;
  logic             err;
  logic             counted;

  always_comb begin
    pred = sr[27] ^ sr[30];
    err  = din ^ pred;
    // An error on the wrap bit opens the new window with a count of one.
    win_sum = (win_cnt == WIN_LAST) ? {7'd0, err} : win_err + {7'd0, err};

    state_nx    = state;
    sr_nx       = sr;
    seed_cnt_nx = seed_cnt;
    good_run_nx = good_run;
    win_cnt_nx  = win_cnt;
    win_err_nx  = win_err;
    pulse_nx    = 1'b0;
    counted     = 1'b0;
    count_nx    = err_count;

    if (din_valid) begin
      case (state)
        SEED: begin
          sr_nx       = {sr[29:0], din};
          seed_cnt_nx = seed_cnt + 5'd1;
          if (seed_cnt == 5'd30) state_nx = VERIFY;
        end
        VERIFY: begin
          sr_nx = {sr[29:0], din};
          if (sr == 31'd0 || err) begin
            good_run_nx = 8'd0;
          end else begin
            good_run_nx = good_run + 8'd1;
            if (good_run == LOCK_LAST) begin
              state_nx   = LOCKED;
              win_cnt_nx = 8'd0;
              win_err_nx = 8'd0;
            end
          end
        end
        LOCKED: begin
          // Free-run on the own prediction so one flipped bit is one error.
          sr_nx      = {sr[29:0], pred};
          pulse_nx   = err;
          counted    = err;
          win_cnt_nx = (win_cnt == WIN_LAST) ? 8'd0 : win_cnt + 8'd1;
          win_err_nx = win_sum;
          if (err && win_sum >= THRESH) begin
            state_nx    = SEED;
            seed_cnt_nx = 5'd0;
            good_run_nx = 8'd0;
            win_cnt_nx  = 8'd0;
            win_err_nx  = 8'd0;
          end
        end
        default: state_nx = SEED;
      endcase
    end

    if (clear_cnt) begin
      count_nx = counted ? CNT_ONE : '0;
    end else if (counted && err_count != CNT_MAX) begin
      count_nx = err_count + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state     <= SEED;
      sr        <= 31'd0;
      seed_cnt  <= 5'd0;
      good_run  <= 8'd0;
      win_cnt   <= 8'd0;
      win_err   <= 8'd0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_nx;
      sr        <= sr_nx;
      seed_cnt  <= seed_cnt_nx;
      good_run  <= good_run_nx;
      win_cnt   <= win_cnt_nx;
      win_err   <= win_err_nx;
      locked    <= (state == LOCKED);
      err_pulse <= pulse_nx;
      err_count <= count_nx;
    end
  end

endmodule

`default_nettype wire
